skew_deskew_unit: RTL and testbench

//  Parametrised lane skew/deskew stage for systolic array edges. N lanes of DATA_WIDTH.

---
 rtl/skew_deskew_unit.sv | 168 ++++++++++++++++
 tb/tb_skew_deskew_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_deskew_unit.sv
// -----------------------------------------------------------------------------
// skew_deskew_unit
//   Lane skew/deskew stage for the edges of a systolic array. N lanes of
//   DATA_WIDTH bits each. In skew mode lane i is delayed by i*STEP advance
//   cycles; in deskew mode by (N-1-i)*STEP. The delay chains move only on
//   advance cycles (accepted beat or drain). After the last beat of a stream
//   the unit drains itself with bubbles and pulses done.
//
// Ports
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset
//   mode       0 = skew, 1 = deskew (taken from the first beat of a stream)
//   in_valid   input beat present
//   in_last    final beat of the stream (qualified by in_valid)
//   in_ready   unit accepts a beat (low while draining)
//   in_data    lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_data   delayed lanes, same packing
//   out_valid  per-lane valid, meaningful on advance cycles
//   busy       a stream is in progress
//   done       one-cycle pulse after the stream has fully drained
// -----------------------------------------------------------------------------
module skew_deskew_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int STEP       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [DATA_WIDTH*N-1:0] in_data,
  output logic [DATA_WIDTH*N-1:0] out_data,
  output logic [N-1:0]          out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int MAXD  = (N - 1) * STEP;
  localparam int DEPTH = (MAXD > 0) ? MAXD : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            mode_r;
  logic            done_nxt;
  logic            accept;
  logic            advance;
  logic            mode_eff;

  assign in_ready = (state != DRAIN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign advance  = accept | (state == DRAIN);
  // Mode is only live before a stream starts; afterwards the latched copy rules.
  assign mode_eff = (state == IDLE) ? mode : mode_r;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (accept) begin
          if (in_last) begin
            if (MAXD > 0) begin
              state_nxt = DRAIN;
              cnt_nxt   = CW'(MAXD);
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            state_nxt = RUN;
          end
        end
      end
      DRAIN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      if (state == IDLE && accept) mode_r <= mode;
    end
  end

  // Each lane keeps only as many stages as its deeper mode needs; the tap for
  // the active mode is picked at the output.
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int DS = i * STEP;
    localparam int DD = (N - 1 - i) * STEP;
    localparam int DL = (DS > DD) ? DS : DD;

    logic [DATA_WIDTH-1:0] lane_in;
    logic [DATA_WIDTH-1:0] tap_s, tap_d;
    logic                  vld_s, vld_d;

    assign lane_in = in_data[i*DATA_WIDTH +: DATA_WIDTH];

    if (DL > 0) begin : g_chain
      logic [DATA_WIDTH-1:0] cd [DL];
      logic [DL-1:0]         cv;

      // NOTE: the chain data is reset (not just the valids) because out_data
      // must read zero right after reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DL; k++) cd[k] <= '0;
          cv <= '0;
        end else if (advance) begin
          cd[0] <= accept ? lane_in : '0;
          cv[0] <= accept;
          for (int k = 1; k < DL; k++) begin
            cd[k] <= cd[k-1];
            cv[k] <= cv[k-1];
          end
        end
      end

      if (DS > 0) begin : g_ts
        assign tap_s = cd[DS-1];
        assign vld_s = cv[DS-1] & advance;
      end else begin : g_ts0
        assign tap_s = accept ? lane_in : '0;
        assign vld_s = accept;
      end

      if (DD > 0) begin : g_td
        assign tap_d = cd[DD-1];
        assign vld_d = cv[DD-1] & advance;
      end else begin : g_td0
        assign tap_d = accept ? lane_in : '0;
        assign vld_d = accept;
      end
    end else begin : g_pass
      assign tap_s = accept ? lane_in : '0;
      assign vld_s = accept;
      assign tap_d = tap_s;
      assign vld_d = vld_s;
    end

    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = mode_eff ? tap_d : tap_s;
    assign out_valid[i] = mode_eff ? vld_d : vld_s;
  end

endmodule

// File: tb/tb_skew_deskew_unit.sv
// -----------------------------------------------------------------------------
// tb_skew_deskew_unit
//   Three instances share one stimulus: u0 (N=4, STEP=1), u1 (N=4, STEP=2)
//   and u2 (N=1). Each has its own reference model built from the stream
//   history (a list of past advance inputs) and the stream-level rules.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_skew_deskew_unit;

  logic        clk = 1'b0;
  logic        rst, mode, in_valid, in_last;
  logic [63:0] in_data;

  always #5 clk = ~clk;

  logic        rdy0, rdy1, rdy2, busy0, busy1, busy2, done0, done1, done2;
  logic [63:0] od0, od1;
  logic [15:0] od2;
  logic [3:0]  ov0, ov1;
  logic [0:0]  ov2;

  skew_deskew_unit #(.DATA_WIDTH(16), .N(4), .STEP(1)) u0 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy0), .in_data(in_data), .out_data(od0), .out_valid(ov0),
    .busy(busy0), .done(done0));

  skew_deskew_unit #(.DATA_WIDTH(16), .N(4), .STEP(2)) u1 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy1), .in_data(in_data), .out_data(od1), .out_valid(ov1),
    .busy(busy1), .done(done1));

  skew_deskew_unit #(.DATA_WIDTH(16), .N(1), .STEP(1)) u2 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rdy2), .in_data(in_data[15:0]), .out_data(od2), .out_valid(ov2),
    .busy(busy2), .done(done2));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---- reference model: 0 idle, 1 streaming, 2 draining ----
  int          m_n    [3] = '{4, 4, 1};
  int          m_step [3] = '{1, 2, 1};
  int          st     [3];
  int          left   [3];
  bit          done_m [3];
  bit          mode_m [3];
  logic [64:0] hist   [3][$];   // hist[k][j] = input of the advance j+1 advances ago

  // last sampled outputs, for scenario-specific checks
  logic [63:0] s_data  [3];
  logic [3:0]  s_valid [3];
  logic        s_rdy [3], s_busy [3], s_done [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] beat(input int b);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = 16'(b * 256 + i);
    return r;
  endfunction

  task automatic model_expect(input int k, output logic [63:0] ed, output logic [3:0] ev,
                              output logic er, output logic eb, output logic edn);
    int n   = m_n[k];
    int s   = m_step[k];
    bit acc = in_valid && (st[k] != 2);
    bit adv = acc || (st[k] == 2);
    bit me  = (st[k] == 0) ? mode : mode_m[k];
    ed = '0;
    ev = '0;
    for (int i = 0; i < n; i++) begin
      int d = me ? (n - 1 - i) * s : i * s;
      if (d == 0) begin
        if (acc) ed[16*i +: 16] = in_data[16*i +: 16];
        ev[i] = acc;
      end else begin
        ed[16*i +: 16] = hist[k][d-1][16*i +: 16];
        ev[i] = hist[k][d-1][64] & adv;
      end
    end
    er  = (st[k] != 2);
    eb  = (st[k] != 0);
    edn = done_m[k];
  endtask

  task automatic model_update(input int k);
    int maxd = (m_n[k] - 1) * m_step[k];
    bit acc  = in_valid && (st[k] != 2);
    bit adv  = acc || (st[k] == 2);
    if (rst) begin
      st[k] = 0; left[k] = 0; done_m[k] = 0; mode_m[k] = 0;
      hist[k].delete();
      for (int j = 0; j < maxd; j++) hist[k].push_back('0);
      return;
    end
    done_m[k] = 0;
    if (adv && maxd > 0) begin
      hist[k].push_front({acc, acc ? in_data : 64'h0});
      void'(hist[k].pop_back());
    end
    if (st[k] == 0 && acc) mode_m[k] = mode;
    if (st[k] == 2) begin
      left[k]--;
      if (left[k] == 0) begin st[k] = 0; done_m[k] = 1; end
    end else if (acc) begin
      if (in_last) begin
        if (maxd > 0) begin st[k] = 2; left[k] = maxd; end
        else begin st[k] = 0; done_m[k] = 1; end
      end else begin
        st[k] = 1;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit v, input bit l, input bit m, input logic [63:0] d);
    logic [63:0] ed, ad;
    logic [3:0]  ev, av;
    logic        er, eb, edn, ar, ab, adn;
    @(negedge clk);
    rst = r; in_valid = v; in_last = l; mode = m; in_data = d;
    #1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin ad = od0; av = ov0; ar = rdy0; ab = busy0; adn = done0; end
        1:       begin ad = od1; av = ov1; ar = rdy1; ab = busy1; adn = done1; end
        default: begin ad = {48'h0, od2}; av = {3'b0, ov2}; ar = rdy2; ab = busy2; adn = done2; end
      endcase
      model_expect(k, ed, ev, er, eb, edn);
      check($sformatf("u%0d out_data", k), ad, ed);
      check($sformatf("u%0d out_valid", k), 64'(av), 64'(ev));
      check($sformatf("u%0d in_ready", k), 64'(ar), 64'(er));
      check($sformatf("u%0d busy", k), 64'(ab), 64'(eb));
      check($sformatf("u%0d done", k), 64'(adn), 64'(edn));
      s_data[k] = ad; s_valid[k] = av; s_rdy[k] = ar; s_busy[k] = ab; s_done[k] = adn;
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, '0);
  endtask

  task automatic reset_cycle();
    cycle(1, 0, 0, 0, '0);
  endtask

  task automatic scenario_skew();
    reset_cycle();
    cycle(0, 1, 0, 0, beat(0));
    check("s1 lane0 valid c0", 64'(s_valid[0][0]), 64'(1));
    cycle(0, 1, 0, 0, beat(1));
    check("s1 lane0 data c1", 64'(s_data[0][15:0]), 64'h0100);
    cycle(0, 1, 1, 0, beat(2));
    idle(1);
    check("s1 lane3 data c3", 64'(s_data[0][63:48]), 64'h0003);
    check("s1 lane3 valid c3", 64'(s_valid[0][3]), 64'(1));
    check("s1 in_ready c3", 64'(s_rdy[0]), 64'(0));
    idle(2);
    check("s1 lane3 data c5", 64'(s_data[0][63:48]), 64'h0203);
    check("s1 done c5", 64'(s_done[0]), 64'(0));
    idle(1);
    check("s1 done c6", 64'(s_done[0]), 64'(1));
    idle(1);
    check("s1 done c7", 64'(s_done[0]), 64'(0));
    idle(4);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);

    // 1: skew, 3 beats
    scenario_skew();

    // 2: deskew, mode toggled after the first beat
    reset_cycle();
    cycle(0, 1, 0, 1, beat(0));
    check("s2 lane3 data c0", 64'(s_data[0][63:48]), 64'h0003);
    cycle(0, 1, 0, 0, beat(1));
    cycle(0, 1, 1, 0, beat(2));
    idle(1);
    check("s2 lane0 data c3", 64'(s_data[0][15:0]), 64'h0000);
    check("s2 lane0 valid c3", 64'(s_valid[0][0]), 64'(1));
    check("s2 lane3 valid c3", 64'(s_valid[0][3]), 64'(0));
    idle(2);
    check("s2 lane0 data c5", 64'(s_data[0][15:0]), 64'h0200);
    idle(6);

    // 3: stall between beats
    reset_cycle();
    cycle(0, 1, 0, 0, beat(0));
    cycle(0, 1, 0, 0, beat(1));
    cycle(0, 0, 0, 0, '0);
    check("s3 no valid on stall", 64'(s_valid[0]), 64'(0));
    cycle(0, 0, 1, 0, '0);
    check("s3 no valid, lone last", 64'(s_valid[0]), 64'(0));
    cycle(0, 1, 0, 0, beat(2));
    cycle(0, 0, 0, 0, '0);
    cycle(0, 1, 1, 0, beat(3));
    check("s3 lane3 data", 64'(s_data[0][63:48]), 64'h0003);
    check("s3 lane3 valid", 64'(s_valid[0][3]), 64'(1));
    idle(10);

    // 4: single beat with last, STEP=2 instance
    reset_cycle();
    cycle(0, 1, 1, 0, beat(5));
    for (int j = 1; j <= 6; j++) begin
      idle(1);
      check($sformatf("s4 busy drain %0d", j), 64'(s_busy[1]), 64'(1));
      check($sformatf("s4 lane3 valid drain %0d", j), 64'(s_valid[1][3]), 64'(j == 6));
    end
    idle(1);
    check("s4 done", 64'(s_done[1]), 64'(1));
    check("s4 busy after", 64'(s_busy[1]), 64'(0));

    // 5: reset during drain, then a fresh stream
    reset_cycle();
    cycle(0, 1, 0, 0, beat(0));
    cycle(0, 1, 0, 0, beat(1));
    cycle(0, 1, 1, 0, beat(2));
    idle(1);
    reset_cycle();
    idle(1);
    check("s5 out_valid", 64'(s_valid[0]), 64'(0));
    check("s5 out_data", s_data[0], 64'h0);
    check("s5 busy", 64'(s_busy[0]), 64'(0));
    check("s5 done", 64'(s_done[0]), 64'(0));
    check("s5 in_ready", 64'(s_rdy[0]), 64'(1));
    scenario_skew();

    // 6: N=1 pass-through
    reset_cycle();
    cycle(0, 1, 1, 0, 64'hBEEF);
    check("s6 data", 64'(s_data[2][15:0]), 64'hBEEF);
    check("s6 valid", 64'(s_valid[2][0]), 64'(1));
    idle(1);
    check("s6 done", 64'(s_done[2]), 64'(1));
    idle(8);

    // random traffic
    for (int t = 0; t < 4000; t++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 6) == 0),
            1'($urandom),
            {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
